// File: rtl/sumador_acumulador_param_pkg.sv
// rtl/sumador_acumulador_param_pkg.sv - shared mode codes and reset value for the registered arithmetic unit
package sumador_acumulador_param_pkg;

  typedef enum logic [2:0] {
    MODO_HOLD  = 3'b000,
    MODO_ADD   = 3'b001,
    MODO_SUB   = 3'b010,
    MODO_CLEAR = 3'b011,
    MODO_ACC   = 3'b100,
    MODO_UP    = 3'b101,
    MODO_DOWN  = 3'b110,
    MODO_LOAD  = 3'b111
  } modo_e;

  // Every bit of Q takes this value on reset.
  localparam logic Q_RST_BIT = 1'b0;

endpackage

// File: rtl/sumador_acumulador_param_sumador.sv
// rtl/sumador_acumulador_param_sumador.sv - combinational WIDTH-bit adder with carry-out and signed overflow
module sumador_nbits #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             ci,
  output logic [WIDTH-1:0] S,
  output logic             co,
  output logic             ovf
);

  assign {co, S} = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, ci};

  // Signed overflow: operands share a sign and the result sign differs from it.
  assign ovf = (X[WIDTH-1] == Y[WIDTH-1]) && (S[WIDTH-1] != X[WIDTH-1]);

endmodule

// File: rtl/sumador_acumulador_param.sv
// rtl/sumador_acumulador_param.sv - WIDTH-bit registered add/sub/accumulate/count unit with status flags
module sumador_acumulador_param
  import sumador_acumulador_param_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             ENB,
  input  logic [2:0]       MODO,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF,
  output logic             ZERO
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] Q_RST    = {WIDTH{Q_RST_BIT}};

  modo_e            modo;
  logic [WIDTH-1:0] add_x, add_y, add_s;
  logic             add_ci, add_co, add_ovf;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_rco, nxt_ovf;

  assign modo = modo_e'(MODO);

  // Steer the shared adder; subtract/decrement go through X + ~Y + ~Cin so borrow = ~co.
  always_comb begin
    add_x  = A;
    add_y  = B;
    add_ci = Cin;
    case (modo)
      MODO_SUB: begin
        add_y  = ~B;
        add_ci = ~Cin;
      end
      MODO_ACC: begin
        add_x = Q;
        add_y = A;
      end
      MODO_UP: begin
        add_x  = Q;
        add_y  = '0;
        add_ci = 1'b1;
      end
      MODO_DOWN: begin
        add_x  = Q;
        add_y  = ~ONE;
        add_ci = 1'b1;
      end
      default: ;
    endcase
  end

  sumador_nbits #(.WIDTH(WIDTH)) u_sumador (
    .X   (add_x),
    .Y   (add_y),
    .ci  (add_ci),
    .S   (add_s),
    .co  (add_co),
    .ovf (add_ovf)
  );

  // Select next result and flags; saturation clamps Q but leaves RCO/OVF from the raw sum.
  always_comb begin
    nxt_q   = Q;
    nxt_rco = RCO;
    nxt_ovf = OVF;
    case (modo)
      MODO_ADD, MODO_ACC, MODO_UP: begin
        nxt_rco = add_co;
        nxt_ovf = add_ovf;
        nxt_q   = (SAT && add_co) ? ALL_ONES : add_s;
      end
      MODO_SUB, MODO_DOWN: begin
        nxt_rco = ~add_co;
        nxt_ovf = add_ovf;
        nxt_q   = (SAT && !add_co) ? '0 : add_s;
      end
      MODO_CLEAR: begin
        nxt_q   = '0;
        nxt_rco = 1'b0;
        nxt_ovf = 1'b0;
      end
      MODO_LOAD: begin
        nxt_q   = A;
        nxt_rco = 1'b0;
        nxt_ovf = 1'b0;
      end
      default: ;
    endcase
  end

  // Result and flag registers: reset wins, then enable freezes everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= Q_RST;
      RCO  <= 1'b0;
      OVF  <= 1'b0;
      ZERO <= (Q_RST == '0);
    end else if (ENB) begin
      Q    <= nxt_q;
      RCO  <= nxt_rco;
      OVF  <= nxt_ovf;
      ZERO <= (nxt_q == '0);
    end
  end

endmodule
